// File: rtl/mem_bus_decoder_pkg.sv
// Shared address map, FSM state type and sizing constants for the memory bus decoder.
// Unused map entries have base == top, so they can never be hit.
package mem_bus_decoder_pkg;

   localparam int MAX_SLV = 8;
   localparam int SEL_W   = $clog2(MAX_SLV);

   typedef logic [31:0] addr_t;

   localparam addr_t BRAM_BASE  = 32'h0000_0000;
   localparam addr_t BRAM_TOP   = 32'h0010_0000;
   localparam addr_t UART_BASE  = 32'h0010_0000;
   localparam addr_t UART_TOP   = 32'h0010_0010;
   localparam addr_t CLINT_BASE = 32'h0200_0000;
   localparam addr_t CLINT_TOP  = 32'h0201_0000;
   localparam addr_t CLIC_BASE  = 32'h0280_0000;
   localparam addr_t CLIC_TOP   = 32'h0280_1000;
   localparam addr_t AVL_BASE   = 32'h8000_0000;
   localparam addr_t AVL_TOP    = 32'h9000_0000;

   localparam addr_t slv_base_addr [MAX_SLV] = '{
      BRAM_BASE, UART_BASE, CLINT_BASE, CLIC_BASE, AVL_BASE,
      32'h0, 32'h0, 32'h0};
   localparam addr_t slv_top_addr [MAX_SLV] = '{
      BRAM_TOP, UART_TOP, CLINT_TOP, CLIC_TOP, AVL_TOP,
      32'h0, 32'h0, 32'h0};

   typedef enum logic [1:0] {IDLE, BUSY, DERR} state_e;

endpackage

// File: rtl/mem_bus_decoder_if.sv
// CPU memory port plus broadcast/per-slave bus. "slave" is the decoder's view,
// "master" is the surrounding environment (cpu and peripherals).
interface mem_bus_decoder_if #(
   parameter int NUM_SLV = 5
);
   logic                      memory_valid;
   logic                      memory_instr;
   logic [31:0]               memory_addr;
   logic [31:0]               memory_wdata;
   logic [3:0]                memory_wstrb;
   logic [31:0]               memory_rdata;
   logic                      memory_error;
   logic                      memory_ready;
   logic [NUM_SLV-1:0]        slv_valid;
   logic                      slv_instr;
   logic [31:0]               slv_addr;
   logic [31:0]               slv_wdata;
   logic [3:0]                slv_wstrb;
   logic [NUM_SLV-1:0][31:0]  slv_rdata;
   logic [NUM_SLV-1:0]        slv_ready;

   modport slave (
      input  memory_valid, memory_instr, memory_addr, memory_wdata, memory_wstrb,
      input  slv_rdata, slv_ready,
      output memory_rdata, memory_error, memory_ready,
      output slv_valid, slv_instr, slv_addr, slv_wdata, slv_wstrb
   );

   modport master (
      output memory_valid, memory_instr, memory_addr, memory_wdata, memory_wstrb,
      output slv_rdata, slv_ready,
      input  memory_rdata, memory_error, memory_ready,
      input  slv_valid, slv_instr, slv_addr, slv_wdata, slv_wstrb
   );
endinterface

// File: rtl/mem_bus_decoder_addr_match.sv
// Combinational priority address match: lowest matching slave index wins.
// Range test uses (addr - base) < (top - base), which also yields the rebased address.
module mem_bus_addr_match
   import mem_bus_decoder_pkg::*;
#(
   parameter int                 NUM_SLV    = 5,
   parameter logic [NUM_SLV-1:0] SLV_REBASE = 5'b01111
) (
   input  logic [31:0]        addr,
   output logic               hit,
   output logic [NUM_SLV-1:0] onehot,
   output logic [SEL_W-1:0]   idx,
   output logic [31:0]        addr_out
);

   logic [31:0] offs;

   always_comb begin
      hit      = 1'b0;
      onehot   = '0;
      idx      = '0;
      addr_out = addr;
      offs     = '0;
      for (int i = NUM_SLV - 1; i >= 0; i--) begin
         offs = addr - slv_base_addr[i];
         if (offs < (slv_top_addr[i] - slv_base_addr[i])) begin
            hit       = 1'b1;
            onehot    = '0;
            onehot[i] = 1'b1;
            idx       = SEL_W'(i);
            addr_out  = SLV_REBASE[i] ? offs : addr;
         end
      end
   end

endmodule

// File: rtl/mem_bus_decoder.sv
// Parametrised memory bus decoder with registered slave select and error responses.
// Optional MEM_BUS_TIMEOUT_EN adds a BUSY timeout that returns an error response.
module mem_bus_decoder
   import mem_bus_decoder_pkg::*;
#(
   parameter int                 NUM_SLV    = 5,
   parameter logic [NUM_SLV-1:0] SLV_REBASE = 5'b01111,
   parameter int                 TIMEOUT    = 1024
) (
   input  logic                clock,
   input  logic                reset,
   mem_bus_decoder_if.slave    bus,
   output logic                busy,
   output logic [15:0]         err_count
);

   state_e               state_q, state_d;
   logic [SEL_W-1:0]     sel_q, sel_d;
   logic [15:0]          err_q, err_d;
   logic                 err_inc;
   logic                 hit;
   logic [NUM_SLV-1:0]   hit_oh;
   logic [SEL_W-1:0]     hit_idx;
   logic [31:0]          match_addr;
   logic                 ready_sel;
   logic [NUM_SLV-1:0]   slv_valid;
   logic                 mem_ready, mem_error;
   logic [31:0]          mem_rdata;

`ifdef MEM_BUS_TIMEOUT_EN
   localparam int TMR_W = $clog2(TIMEOUT) + 1;
   logic [TMR_W-1:0]     timer_q, timer_d;
`endif

   mem_bus_addr_match #(
      .NUM_SLV    (NUM_SLV),
      .SLV_REBASE (SLV_REBASE)
   ) u_match (
      .addr     (bus.memory_addr),
      .hit      (hit),
      .onehot   (hit_oh),
      .idx      (hit_idx),
      .addr_out (match_addr)
   );

   assign ready_sel = bus.slv_ready[sel_q];

   always_comb begin
      state_d   = state_q;
      sel_d     = sel_q;
      err_inc   = 1'b0;
      slv_valid = '0;
      mem_ready = 1'b0;
      mem_error = 1'b0;
      mem_rdata = '0;
`ifdef MEM_BUS_TIMEOUT_EN
      timer_d   = timer_q;
`endif
      case (state_q)
         IDLE: begin
            if (bus.memory_valid) begin
               if (hit) begin
                  slv_valid = hit_oh;
                  sel_d     = hit_idx;
                  state_d   = BUSY;
`ifdef MEM_BUS_TIMEOUT_EN
                  timer_d   = '0;
`endif
               end else begin
                  state_d = DERR;
               end
            end
         end
         BUSY: begin
            // Only the registered slave can complete the transaction.
            if (ready_sel) begin
               mem_ready = 1'b1;
               mem_rdata = bus.slv_rdata[sel_q];
               state_d   = IDLE;
            end
`ifdef MEM_BUS_TIMEOUT_EN
            else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
               mem_ready = 1'b1;
               mem_error = 1'b1;
               err_inc   = 1'b1;
               state_d   = IDLE;
            end else begin
               timer_d = timer_q + 1'b1;
            end
`endif
         end
         DERR: begin
            mem_ready = 1'b1;
            mem_error = 1'b1;
            err_inc   = 1'b1;
            state_d   = IDLE;
         end
         default: state_d = IDLE;
      endcase
      err_d = (err_inc && err_q != 16'hFFFF) ? err_q + 16'd1 : err_q;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         sel_q   <= '0;
         err_q   <= '0;
`ifdef MEM_BUS_TIMEOUT_EN
         timer_q <= '0;
`endif
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         err_q   <= err_d;
`ifdef MEM_BUS_TIMEOUT_EN
         timer_q <= timer_d;
`endif
      end
   end

   // Broadcast outputs are forced low while reset is held so every output reads 0.
   assign bus.slv_valid    = reset ? slv_valid : '0;
   assign bus.slv_instr    = reset & bus.memory_instr;
   assign bus.slv_addr     = reset ? match_addr : '0;
   assign bus.slv_wdata    = reset ? bus.memory_wdata : '0;
   assign bus.slv_wstrb    = reset ? bus.memory_wstrb : '0;
   assign bus.memory_ready = mem_ready;
   assign bus.memory_error = mem_error;
   assign bus.memory_rdata = mem_rdata;
   assign busy             = (state_q != IDLE);
   assign err_count        = err_q;

endmodule

// File: tb/tb_mem_bus_decoder.sv
// Directed-vector bench for mem_bus_decoder; timeout vectors depend on MEM_BUS_TIMEOUT_EN.
module tb_mem_bus_decoder;

   localparam int NUM_SLV = 5;

   logic        clock = 1'b0;
   logic        reset;
   logic        busy;
   logic [15:0] err_count;
   int          n_chk  = 0;
   int          n_fail = 0;

   mem_bus_decoder_if #(.NUM_SLV(NUM_SLV)) bus ();

   mem_bus_decoder #(
      .NUM_SLV    (NUM_SLV),
      .SLV_REBASE (5'b01111),
      .TIMEOUT    (8)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .bus       (bus),
      .busy      (busy),
      .err_count (err_count)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   // Start of a cycle: inputs change 2 time units after the rising edge.
   task automatic cyc();
      @(posedge clock);
      #2;
      bus.memory_valid = 1'b0;
      bus.slv_ready    = '0;
   endtask

   task automatic req(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d, input logic ins);
      bus.memory_valid = 1'b1;
      bus.memory_addr  = a;
      bus.memory_wstrb = s;
      bus.memory_wdata = d;
      bus.memory_instr = ins;
   endtask

   initial begin
      reset            = 1'b0;
      bus.memory_valid = 1'b0;
      bus.memory_instr = 1'b0;
      bus.memory_addr  = '0;
      bus.memory_wdata = '0;
      bus.memory_wstrb = '0;
      bus.slv_rdata    = '0;
      bus.slv_ready    = '0;
      repeat (3) @(posedge clock);
      #2;
      chk("rst_ready",  32'(bus.memory_ready), 32'd0);
      chk("rst_error",  32'(bus.memory_error), 32'd0);
      chk("rst_busy",   32'(busy), 32'd0);
      chk("rst_errcnt", 32'(err_count), 32'd0);
      chk("rst_valid",  32'(bus.slv_valid), 32'd0);
      reset = 1'b1;

      // bram read, ready two cycles after the request
      cyc(); req(32'h0000_0040, 4'h0, 32'h0, 1'b1); #2;
      chk("rd_valid", 32'(bus.slv_valid), 32'h01);
      chk("rd_addr",  bus.slv_addr, 32'h40);
      chk("rd_instr", 32'(bus.slv_instr), 32'd1);
      chk("rd_busy0", 32'(busy), 32'd0);
      cyc(); #2;
      chk("rd_pulse", 32'(bus.slv_valid), 32'h00);
      chk("rd_busy1", 32'(busy), 32'd1);
      chk("rd_wait",  32'(bus.memory_ready), 32'd0);
      cyc(); bus.slv_rdata[0] = 32'hDEAD_BEEF; bus.slv_ready[0] = 1'b1; #2;
      chk("rd_ready", 32'(bus.memory_ready), 32'd1);
      chk("rd_rdata", bus.memory_rdata, 32'hDEAD_BEEF);
      chk("rd_error", 32'(bus.memory_error), 32'd0);
      cyc(); #2;
      chk("rd_idle", 32'(busy), 32'd0);

      // uart write
      cyc(); req(32'h0010_0004, 4'hF, 32'h1234_5678, 1'b0); #2;
      chk("wr_valid", 32'(bus.slv_valid), 32'h02);
      chk("wr_addr",  bus.slv_addr, 32'h4);
      chk("wr_wdata", bus.slv_wdata, 32'h1234_5678);
      chk("wr_wstrb", 32'(bus.slv_wstrb), 32'hF);
      cyc(); bus.slv_rdata[1] = 32'h0; bus.slv_ready[1] = 1'b1; #2;
      chk("wr_ready", 32'(bus.memory_ready), 32'd1);
      cyc(); #2;
      chk("wr_busy", 32'(busy), 32'd0);

      // avl is not rebased
      cyc(); req(32'h8000_1000, 4'h0, 32'h0, 1'b0); #2;
      chk("avl_valid", 32'(bus.slv_valid), 32'h10);
      chk("avl_addr",  bus.slv_addr, 32'h8000_1000);
      cyc(); bus.slv_rdata[4] = 32'hCAFE_0004; bus.slv_ready[4] = 1'b1; #2;
      chk("avl_rdata", bus.memory_rdata, 32'hCAFE_0004);

      // unmapped address: decode error one cycle later
      cyc(); req(32'h4000_0000, 4'h0, 32'h0, 1'b0); #2;
      chk("derr_valid", 32'(bus.slv_valid), 32'h00);
      chk("derr_early", 32'(bus.memory_ready), 32'd0);
      cyc(); req(32'h0000_0000, 4'h0, 32'h0, 1'b0); #2;
      chk("derr_ign",   32'(bus.slv_valid), 32'h00);
      chk("derr_ready", 32'(bus.memory_ready), 32'd1);
      chk("derr_error", 32'(bus.memory_error), 32'd1);
      chk("derr_rdata", bus.memory_rdata, 32'h0);
      chk("derr_busy",  32'(busy), 32'd1);
      cyc(); #2;
      chk("derr_cnt",  32'(err_count), 32'd1);
      chk("derr_idle", 32'(busy), 32'd0);

      // uart top is exclusive
      cyc(); req(32'h0010_0010, 4'h0, 32'h0, 1'b0); #2;
      chk("top_valid", 32'(bus.slv_valid), 32'h00);
      cyc(); cyc(); #2;
      chk("top_cnt", 32'(err_count), 32'd2);

      // last bram word, with a competing uart ready in the response cycle
      cyc(); req(32'h000F_FFFC, 4'h0, 32'h0, 1'b0); #2;
      chk("last_valid", 32'(bus.slv_valid), 32'h01);
      chk("last_addr",  bus.slv_addr, 32'h000F_FFFC);
      cyc();
      bus.slv_rdata[0] = 32'h1122_3344; bus.slv_rdata[1] = 32'h55;
      bus.slv_ready    = 5'b00011; #2;
      chk("last_rdata", bus.memory_rdata, 32'h1122_3344);

      // ready in IDLE ignored; unrelated ready in BUSY ignored; async reset mid-BUSY
      cyc(); bus.slv_ready = 5'b11111; #2;
      chk("idle_ready", 32'(bus.memory_ready), 32'd0);
      cyc(); req(32'h0000_0100, 4'h0, 32'h0, 1'b0); #2;
      cyc(); bus.slv_ready[1] = 1'b1; #2;
      chk("oth_ready", 32'(bus.memory_ready), 32'd0);
      chk("oth_busy",  32'(busy), 32'd1);
      cyc(); bus.slv_ready[0] = 1'b1; req(32'h0000_0100, 4'h0, 32'h0, 1'b0);
      #1 reset = 1'b0; #1;
      chk("arst_ready",  32'(bus.memory_ready), 32'd0);
      chk("arst_busy",   32'(busy), 32'd0);
      chk("arst_errcnt", 32'(err_count), 32'd0);
      chk("arst_valid",  32'(bus.slv_valid), 32'h00);
      chk("arst_addr",   bus.slv_addr, 32'h0);
      cyc(); reset = 1'b1;

`ifdef MEM_BUS_TIMEOUT_EN
      // bram never answers: error exactly 8 cycles after the request
      bus.slv_rdata[0] = 32'hFFFF_0000;
      cyc(); req(32'h0000_0200, 4'h0, 32'h0, 1'b0); #2;
      chk("to_valid", 32'(bus.slv_valid), 32'h01);
      for (int k = 1; k < 8; k++) begin
         cyc(); #2;
         chk("to_wait", 32'(bus.memory_ready), 32'd0);
      end
      cyc(); #2;
      chk("to_ready", 32'(bus.memory_ready), 32'd1);
      chk("to_error", 32'(bus.memory_error), 32'd1);
      chk("to_rdata", bus.memory_rdata, 32'h0);
      cyc(); bus.slv_ready[0] = 1'b1; #2;
      chk("to_late", 32'(bus.memory_ready), 32'd0);
      chk("to_cnt",  32'(err_count), 32'd1);
      // ready on the timeout cycle wins
      cyc(); req(32'h0000_0200, 4'h0, 32'h0, 1'b0);
      for (int k = 1; k < 8; k++) cyc();
      cyc(); bus.slv_rdata[0] = 32'h77; bus.slv_ready[0] = 1'b1; #2;
      chk("tw_ready", 32'(bus.memory_ready), 32'd1);
      chk("tw_error", 32'(bus.memory_error), 32'd0);
      chk("tw_rdata", bus.memory_rdata, 32'h77);
      cyc(); #2;
      chk("tw_cnt", 32'(err_count), 32'd1);
`else
      // without the timeout BUSY waits indefinitely
      cyc(); req(32'h0000_0200, 4'h0, 32'h0, 1'b0);
      repeat (20) cyc();
      #2;
      chk("nto_busy",  32'(busy), 32'd1);
      chk("nto_ready", 32'(bus.memory_ready), 32'd0);
      cyc(); bus.slv_rdata[0] = 32'h77; bus.slv_ready[0] = 1'b1; #2;
      chk("nto_rdata", bus.memory_rdata, 32'h77);
      chk("nto_cnt",   32'(err_count), 32'd0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
